// File: rtl/return_desk_pkg.sv
// Shared types and constants for the return desk controller.
// Optional lockout feature is selected with RETURN_DESK_LOCKOUT_EN.
package return_desk_pkg;

  // Controller states; ST_LOCKED is only reachable in the lockout build.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EVAL   = 3'd1,
    ST_DONE   = 3'd2,
    ST_ALARM  = 3'd3,
    ST_LOCKED = 3'd4
  } state_t;

  // Bit positions inside the 3-bit {U,P,C} code.
  localparam int U_BIT = 2;
  localparam int P_BIT = 1;
  localparam int C_BIT = 0;

  localparam int DEFAULT_CNT_W        = 8;
  localparam int DEFAULT_LOCK_STRIKES = 3;

endpackage

// File: rtl/return_desk_ctrl_if.sv
// Front-end / display bundle for the return desk controller.
//
// Handshake: an item transfers on a rising clk edge where item_valid and
// item_ready are both high. The source holds item_valid, upc and mark
// stable until that edge; item_valid while item_ready is low has no effect.
interface return_desk_ctrl_if
  import return_desk_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);
  logic             item_valid;
  logic             item_ready;
  logic [2:0]       upc;
  logic             mark;
  logic             alarm_ack;
  logic             item_done;
  logic             discounted;
  logic             alarm;
  logic             locked;
  logic [CNT_W-1:0] item_count;
  logic [CNT_W-1:0] discount_count;
  logic [CNT_W-1:0] strike_count;

  // Scanner/switch side.
  modport master (
    output item_valid, upc, mark, alarm_ack,
    input  item_ready, item_done, discounted, alarm, locked,
    input  item_count, discount_count, strike_count
  );

  // Controller side.
  modport slave (
    input  item_valid, upc, mark, alarm_ack,
    output item_ready, item_done, discounted, alarm, locked,
    output item_count, discount_count, strike_count
  );
endinterface

// File: rtl/return_desk_ctrl_upc_classifier.sv
// Pure combinational classification of a captured item code and mark.
module upc_classifier (
  input  logic u,
  input  logic p,
  input  logic c,
  input  logic m,
  output logic discount,
  output logic stolen
);

  // Discount when the P bit is set or both U and C are set; stolen when an
  // unmarked item lacks the codes that prove it was sold.
  always_comb begin
    discount = p | (u & c);
    stolen   = (~p & ~c & ~m) | (u & ~p & ~m);
  end

endmodule

// File: rtl/return_desk_ctrl.sv
// Return desk sequencing controller: accepts one item at a time, classifies
// it, then completes the return or holds a theft alarm until acknowledged.
// Define RETURN_DESK_LOCKOUT_EN to lock the desk after enough strikes.
module return_desk_ctrl
  import return_desk_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
`ifdef RETURN_DESK_LOCKOUT_EN
  , parameter int LOCK_STRIKES = DEFAULT_LOCK_STRIKES
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  return_desk_ctrl_if.slave  bus,
  output state_t             state_dbg
);

  state_t           state;
  logic [2:0]       upc_q;
  logic             mark_q;
  logic             ready_q;
  logic             done_q;
  logic             disc_q;
  logic             alarm_q;
  logic             locked_q;
  logic [CNT_W-1:0] item_q;
  logic [CNT_W-1:0] disc_cnt_q;
  logic [CNT_W-1:0] strike_q;
  logic             cls_discount;
  logic             cls_stolen;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Classification works only on the captured code, never on live inputs.
  upc_classifier u_classifier (
    .u        (upc_q[U_BIT]),
    .p        (upc_q[P_BIT]),
    .c        (upc_q[C_BIT]),
    .m        (mark_q),
    .discount (cls_discount),
    .stolen   (cls_stolen)
  );

  // Main sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      upc_q      <= '0;
      mark_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      disc_q     <= 1'b0;
      alarm_q    <= 1'b0;
      locked_q   <= 1'b0;
      item_q     <= '0;
      disc_cnt_q <= '0;
      strike_q   <= '0;
    end else begin
      done_q <= 1'b0;
      disc_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.item_valid) begin
            upc_q   <= bus.upc;
            mark_q  <= bus.mark;
            ready_q <= 1'b0;
            state   <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          item_q <= sat_inc(item_q);
          if (cls_discount) disc_cnt_q <= sat_inc(disc_cnt_q);
          if (cls_stolen) begin
            strike_q <= sat_inc(strike_q);
            alarm_q  <= 1'b1;
            state    <= ST_ALARM;
          end else begin
            done_q <= 1'b1;
            disc_q <= cls_discount;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        ST_ALARM: begin
          if (bus.alarm_ack) begin
            alarm_q <= 1'b0;
`ifdef RETURN_DESK_LOCKOUT_EN
            if (32'(strike_q) >= LOCK_STRIKES) begin
              locked_q <= 1'b1;
              state    <= ST_LOCKED;
            end else begin
              ready_q <= 1'b1;
              state   <= ST_IDLE;
            end
`else
            ready_q <= 1'b1;
            state   <= ST_IDLE;
`endif
          end
        end
`ifdef RETURN_DESK_LOCKOUT_EN
        ST_LOCKED: begin
          ready_q  <= 1'b0;
          locked_q <= 1'b1;
        end
`endif
        default: begin
          ready_q <= 1'b1;
          alarm_q <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.item_ready     = ready_q;
  assign bus.item_done      = done_q;
  assign bus.discounted     = disc_q;
  assign bus.alarm          = alarm_q;
`ifdef RETURN_DESK_LOCKOUT_EN
  assign bus.locked         = locked_q;
`else
  assign bus.locked         = 1'b0;
`endif
  assign bus.item_count     = item_q;
  assign bus.discount_count = disc_cnt_q;
  assign bus.strike_count   = strike_q;
  assign state_dbg          = state;

`ifndef RETURN_DESK_LOCKOUT_EN
  // locked_q only carries meaning in the lockout build.
  logic unused_locked;
  assign unused_locked = locked_q;
`endif

endmodule

// File: tb/tb_return_desk_ctrl.sv
// Self-checking bench for return_desk_ctrl; also covers the lockout build
// when RETURN_DESK_LOCKOUT_EN is defined.
module tb_return_desk_ctrl;
  import return_desk_pkg::*;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;
  localparam int LOCK_N  = 3;

  logic   clk = 1'b0;
  logic   reset_n;
  state_t state_dbg;

  return_desk_ctrl_if #(.CNT_W(CNT_W)) bus ();

  return_desk_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  logic exp_ready, exp_done, exp_disc, exp_alarm, exp_locked;
  int   m_items, m_discs, m_strikes;
  logic [1:0] exp_q[$];   // {discount, stolen} per accepted item

  function automatic logic [1:0] classify(input logic [2:0] code, input logic m);
    logic u, p, c;
    u = code[2]; p = code[1]; c = code[0];
    return {(p | (u & c)), ((~p & ~c & ~m) | (u & ~p & ~m))};
  endfunction

  function automatic int sat(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_ready = 1'b1; exp_done = 1'b0; exp_disc = 1'b0;
    exp_alarm = 1'b0; exp_locked = 1'b0;
    m_items = 0; m_discs = 0; m_strikes = 0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("item_ready", bus.item_ready, exp_ready);
      chk("item_done", bus.item_done, exp_done);
      chk("discounted", bus.discounted, exp_disc);
      chk("alarm", bus.alarm, exp_alarm);
      chk("locked", bus.locked, exp_locked);
      chk("item_count", bus.item_count, m_items);
      chk("discount_count", bus.discount_count, m_discs);
      chk("strike_count", bus.strike_count, m_strikes);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.item_valid = 1'b0;
    bus.alarm_ack = 1'b0;
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Offer one item from IDLE. Returns one tick after DONE->IDLE for a clean
  // item, or one tick into ALARM for a stolen item.
  task automatic offer_item(input logic [2:0] code, input logic m);
    logic [1:0] outcome;
    bus.item_valid = 1'b1;
    bus.upc = code;
    bus.mark = m;
    tick();
    bus.item_valid = 1'b0;
    bus.upc = 3'($urandom_range(0, 7));
    bus.mark = 1'($urandom_range(0, 1));
    exp_q.push_back(classify(code, m));
    exp_ready = 1'b0;
    tick();
    outcome = exp_q.pop_front();
    m_items = sat(m_items);
    if (outcome[1]) m_discs = sat(m_discs);
    if (outcome[0]) begin
      m_strikes = sat(m_strikes);
      exp_alarm = 1'b1;
    end else begin
      exp_done = 1'b1;
      exp_disc = outcome[1];
      tick();
      exp_done = 1'b0;
      exp_disc = 1'b0;
      exp_ready = 1'b1;
    end
  endtask

  // Hold the alarm for 'hold' more cycles (poking item_valid meanwhile),
  // then acknowledge for one edge.
  task automatic ack_alarm(input int hold);
    bus.item_valid = 1'b1;
    bus.upc = 3'($urandom_range(0, 7));
    repeat (hold) tick();
    bus.item_valid = 1'b0;
    bus.alarm_ack = 1'b1;
    tick();
    exp_alarm = 1'b0;
`ifdef RETURN_DESK_LOCKOUT_EN
    if (m_strikes >= LOCK_N) exp_locked = 1'b1;
    else exp_ready = 1'b1;
`else
    exp_ready = 1'b1;
`endif
    bus.alarm_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    bus.item_valid = 1'b0;
    bus.upc = 3'b000;
    bus.mark = 1'b0;
    bus.alarm_ack = 1'b0;
    model_reset();
    tick();
    chk_en = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("reset_ready", bus.item_ready, 1);
    chk("reset_items", bus.item_count, 0);

    // Discounted clean item.
    offer_item(3'b010, 1'b0);
    chk("t1_items", bus.item_count, 1);
    chk("t1_discs", bus.discount_count, 1);
    chk("t1_strikes", bus.strike_count, 0);

    // Stolen item, alarm held, then acked; then discounted-and-stolen item.
    do_reset();
    offer_item(3'b100, 1'b0);
    chk("t2_alarm", bus.alarm, 1);
    chk("t2_ready", bus.item_ready, 0);
    ack_alarm(4);
    chk("t2_strikes", bus.strike_count, 1);
    chk("t2_ready_after", bus.item_ready, 1);
    offer_item(3'b101, 1'b0);
    ack_alarm(1);
    chk("t2b_discs", bus.discount_count, 1);
    chk("t2b_strikes", bus.strike_count, 2);
    chk("t2b_items", bus.item_count, 2);

    // Back-to-back clean items; item counter saturates.
    do_reset();
    repeat (260) offer_item(3'b000, 1'b1);
    chk("t3_items_sat", bus.item_count, 255);
    chk("t3_discs", bus.discount_count, 0);

    // Full classification sweep.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      logic [3:0] kv;
      kv = 4'(k);
      offer_item(kv[3:1], kv[0]);
      if (exp_alarm) begin
        ack_alarm(1);
        do_reset();
      end
    end

    // Ack held from IDLE: alarm lasts exactly one cycle.
    do_reset();
    bus.alarm_ack = 1'b1;
    repeat (3) tick();
    offer_item(3'b100, 1'b0);
    chk("t4_alarm_on", bus.alarm, 1);
    tick();
    exp_alarm = 1'b0;
    exp_ready = 1'b1;
    chk("t4_alarm_off", bus.alarm, 0);
    bus.alarm_ack = 1'b0;
    tick();
    chk("t4_strikes", bus.strike_count, 1);

    // Reset mid-ALARM.
    do_reset();
    offer_item(3'b000, 1'b0);
    tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("t5_alarm_async", bus.alarm, 0);
    chk("t5_strikes", bus.strike_count, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    chk("t5_ready", bus.item_ready, 1);

    // Three strikes.
    do_reset();
    repeat (3) begin
      offer_item(3'b100, 1'b0);
      ack_alarm(1);
    end
`ifdef RETURN_DESK_LOCKOUT_EN
    chk("t6_locked", bus.locked, 1);
    chk("t6_ready", bus.item_ready, 0);
    bus.item_valid = 1'b1;
    bus.upc = 3'b010;
    repeat (4) tick();
    bus.item_valid = 1'b0;
    chk("t6_items_frozen", bus.item_count, 3);
    do_reset();
    chk("t6_unlocked", bus.locked, 0);
    chk("t6_items_clr", bus.item_count, 0);
    chk("t6_strikes_clr", bus.strike_count, 0);
`else
    chk("t6_not_locked", bus.locked, 0);
    chk("t6_ready", bus.item_ready, 1);
    chk("t6_strikes", bus.strike_count, 3);
`endif

    tick();
    chk("exp_q_drained", exp_q.size(), 0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
